// File: rtl/frame_queue_unpacker_pkg.sv
// Shared pixel-queue definitions: in-band marker words, unpacker state
// encoding, error-flag bit positions and a word classifier.
package frame_queue_unpacker_pkg;

  localparam int QUEUE_W = 17;
  localparam int PIX_W   = 16;

  localparam logic [QUEUE_W-1:0] QUEUE_FRAME_START = 17'h10000;
  localparam logic [QUEUE_W-1:0] QUEUE_ROW_START   = 17'h10001;
  localparam logic [QUEUE_W-1:0] QUEUE_FRAME_END   = 17'h1FFFF;

  localparam int ERR_W            = 4;
  localparam int ERR_ROW_OVERFLOW = 0;
  localparam int ERR_SHORT_ROW    = 1;
  localparam int ERR_GEOMETRY     = 2;
  localparam int ERR_ORPHAN       = 3;

  typedef enum logic [1:0] {
    UNP_IDLE  = 2'd0,
    UNP_FRAME = 2'd1,
    UNP_ROW   = 2'd2
  } unp_state_e;

  typedef enum logic [2:0] {
    WORD_PIXEL       = 3'd0,
    WORD_FRAME_START = 3'd1,
    WORD_ROW_START   = 3'd2,
    WORD_FRAME_END   = 3'd3,
    WORD_UNKNOWN     = 3'd4
  } word_kind_e;

  function automatic word_kind_e classify_word(input logic [QUEUE_W-1:0] word);
    word_kind_e kind;
    if (!word[QUEUE_W-1]) begin
      kind = WORD_PIXEL;
    end else if (word == QUEUE_FRAME_START) begin
      kind = WORD_FRAME_START;
    end else if (word == QUEUE_ROW_START) begin
      kind = WORD_ROW_START;
    end else if (word == QUEUE_FRAME_END) begin
      kind = WORD_FRAME_END;
    end else begin
      kind = WORD_UNKNOWN;
    end
    return kind;
  endfunction

endpackage

// File: rtl/frame_queue_unpacker_skid.sv
// Two-entry valid/ready register pair. The head entry drives the output;
// a push while full is discarded, so the producer must respect `level`.
module pixel_skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              pop;

  always_comb begin
    pop     = (count_q != 2'd0) && out_ready;
    mem_d   = mem_q;
    count_d = count_q;
    if (pop) begin
      mem_d[0] = mem_q[1];
      count_d  = count_q - 2'd1;
    end
    // Write lands at the first free slot after this cycle's pop.
    if (in_valid && (count_d != 2'd2)) begin
      mem_d[count_d[0]] = in_data;
      count_d           = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[0];
  assign level     = count_q;

endmodule

// File: rtl/frame_queue_unpacker.sv
// Pops the 17-bit pixel queue, decodes frame/row markers, and emits a
// coordinate-tagged RGB565 stream with framing flags and sticky errors.
module frame_queue_unpacker
  import frame_queue_unpacker_pkg::*;
#(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272,
  parameter int COORD_W      = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               queue_empty,
  output logic               queue_rd_en,
  input  logic [QUEUE_W-1:0] queue_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic               frame_done,
  output logic [ERR_W-1:0]   err_flags,
  input  logic               err_clear
);

  localparam int ENTRY_W = PIX_W + 2 * COORD_W;
  localparam logic [COORD_W-1:0] ROW_LEN  = COORD_W'(FRAME_WIDTH);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(FRAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(FRAME_HEIGHT - 1);

  if (FRAME_WIDTH < 1 || FRAME_WIDTH >= (1 << COORD_W)) begin : g_width_check
    $error("FRAME_WIDTH must be in 1 .. 2**COORD_W-1");
  end
  if (FRAME_HEIGHT < 1 || FRAME_HEIGHT >= (1 << COORD_W)) begin : g_height_check
    $error("FRAME_HEIGHT must be in 1 .. 2**COORD_W-1");
  end

  unp_state_e         state_q, state_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic               drop_q, drop_d;
  logic               done_q, done_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               inflight_q, inflight_d;
  logic               run_q, run_d;

  logic [ERR_W-1:0]   new_err;
  logic               push_valid;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic [1:0]         skid_level;
  logic               skid_pop;
  logic [2:0]         committed;

  // Decode stage: queue_data is valid whenever a read was issued last cycle.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    drop_d     = drop_q;
    done_d     = 1'b0;
    new_err    = '0;
    push_valid = 1'b0;
    push_data  = {queue_data[PIX_W-1:0], col_q, row_q};
    if (inflight_q) begin
      case (classify_word(queue_data))
        WORD_FRAME_START: begin
          if (state_q != UNP_IDLE) new_err[ERR_GEOMETRY] = 1'b1;
          state_d = UNP_FRAME;
          col_d   = '0;
          row_d   = '0;
          drop_d  = 1'b0;
        end
        WORD_ROW_START: begin
          case (state_q)
            UNP_IDLE: new_err[ERR_ORPHAN] = 1'b1;
            UNP_FRAME: begin
              state_d = UNP_ROW;
              col_d   = '0;
              row_d   = '0;
            end
            default: begin
              if (col_q != ROW_LEN) new_err[ERR_SHORT_ROW] = 1'b1;
              if (row_q == LAST_ROW) begin
                // Too many rows: swallow pixels quietly until frame end.
                new_err[ERR_GEOMETRY] = 1'b1;
                col_d  = ROW_LEN;
                drop_d = 1'b1;
              end else begin
                row_d = row_q + 1'b1;
                col_d = '0;
              end
            end
          endcase
        end
        WORD_FRAME_END: begin
          if (state_q == UNP_IDLE) begin
            new_err[ERR_ORPHAN] = 1'b1;
          end else begin
            done_d = 1'b1;
            if (state_q != UNP_ROW || row_q != LAST_ROW || col_q != ROW_LEN)
              new_err[ERR_GEOMETRY] = 1'b1;
            state_d = UNP_IDLE;
            drop_d  = 1'b0;
          end
        end
        WORD_PIXEL: begin
          if (state_q != UNP_ROW) begin
            new_err[ERR_ORPHAN] = 1'b1;
          end else if (col_q < ROW_LEN) begin
            push_valid = 1'b1;
            col_d      = col_q + 1'b1;
          end else if (!drop_q) begin
            new_err[ERR_ROW_OVERFLOW] = 1'b1;
          end
        end
        default: new_err[ERR_ORPHAN] = 1'b1;
      endcase
    end
  end

  // New errors are ORed in after the clear so a coincident error survives.
  always_comb begin
    err_d = (err_clear ? '0 : err_q) | new_err;
  end

  // Reads are allowed while buffered (after this cycle's pop) plus in-flight words stay below 2.
  always_comb begin
    skid_pop    = pix_valid && pix_ready;
    committed   = {1'b0, skid_level} - {2'b00, skid_pop} + {2'b00, inflight_q};
    queue_rd_en = run_q && !queue_empty && (committed < 3'd2);
    inflight_d  = queue_rd_en;
    run_d       = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UNP_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      drop_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      run_q      <= run_d;
    end
  end

  pixel_skid_buffer #(
    .DATA_W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (push_valid),
    .in_data   (push_data),
    .out_valid (pix_valid),
    .out_ready (pix_ready),
    .out_data  (head_data),
    .level     (skid_level)
  );

  assign pix_data   = head_data[ENTRY_W-1 -: PIX_W];
  assign pix_x      = head_data[2*COORD_W-1 -: COORD_W];
  assign pix_y      = head_data[COORD_W-1:0];
  assign pix_sof    = pix_valid && (pix_x == '0) && (pix_y == '0);
  assign pix_eol    = pix_valid && (pix_x == LAST_COL);
  assign pix_eof    = pix_valid && (pix_x == LAST_COL) && (pix_y == LAST_ROW);
  assign frame_done = done_q;
  assign err_flags  = err_q;

endmodule

// File: tb/tb_frame_queue_unpacker.sv
// Scenario table plus hand sequences for frame_queue_unpacker (W=10, H=3),
// checked against a word-level reference model of the framing rules.
module tb_frame_queue_unpacker;
  import frame_queue_unpacker_pkg::*;

  localparam int W  = 10;
  localparam int H  = 3;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          queue_empty;
  logic          queue_rd_en;
  logic [16:0]   queue_data = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [15:0]   pix_data;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic          frame_done;
  logic [3:0]    err_flags;
  logic          err_clear = 1'b0;

  always #5 clk = ~clk;

  frame_queue_unpacker #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H),
    .COORD_W      (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .queue_empty (queue_empty),
    .queue_rd_en (queue_rd_en),
    .queue_data  (queue_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .frame_done  (frame_done),
    .err_flags   (err_flags),
    .err_clear   (err_clear)
  );

  // Upstream FIFO: data appears one cycle after the read strobe.
  logic [16:0] fifo_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign queue_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (queue_rd_en) begin
      queue_data <= fifo_mem[rd_ptr % 4096];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
  } pix_t;

  typedef struct {
    int         kind;
    int         ready_mode;
    logic [3:0] exp_err;
    int         exp_pix;
    int         exp_done;
  } vec_t;

  logic [16:0] stim_q[$];
  pix_t        exp_q[$];
  logic [3:0]  model_err;
  int          model_done;

  int n_vec = 0;
  int n_err = 0;
  int pix_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int first_acc = -1;
  int last_acc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard, stall stability, strobe sanity.
  logic          prev_stall = 1'b0;
  logic [15:0]   prev_data;
  logic [CW-1:0] prev_x;
  logic [CW-1:0] prev_y;
  always @(negedge clk) begin
    pix_t e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (queue_rd_en) chk("rd_when_empty", {63'd0, queue_empty}, 64'd0);
      if (frame_done) done_cnt++;
      if (prev_stall)
        chk("stall_hold", {25'd0, pix_valid, pix_data, pix_x, pix_y},
            {25'd0, 1'b1, prev_data, prev_x, prev_y});
      if (pix_valid && pix_ready) begin
        pix_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d data=%h, required none",
                   pix_x, pix_y, pix_data);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", 64'(pix_data), 64'(e.d));
          chk("pix_x", 64'(pix_x), 64'(e.x));
          chk("pix_y", 64'(pix_y), 64'(e.y));
          chk("pix_sof", 64'(pix_sof), 64'(e.x == 0 && e.y == 0));
          chk("pix_eol", 64'(pix_eol), 64'(e.x == W - 1));
          chk("pix_eof", 64'(pix_eof), 64'(e.x == W - 1 && e.y == H - 1));
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_x     = pix_x;
      prev_y     = pix_y;
    end
  end

  task automatic put(input logic [16:0] w);
    stim_q.push_back(w);
  endtask

  task automatic put_pixels(input int n);
    for (int i = 0; i < n; i++) put({1'b0, 16'($urandom)});
  endtask

  task automatic put_row(input int n);
    put(QUEUE_ROW_START);
    put_pixels(n);
  endtask

  task automatic put_clean_frame();
    put(QUEUE_FRAME_START);
    for (int r = 0; r < H; r++) put_row(W);
    put(QUEUE_FRAME_END);
  endtask

  task automatic build(input int kind);
    case (kind)
      0: put_clean_frame();
      2: begin
        put(QUEUE_FRAME_START); put_row(W + 1); put_row(W); put_row(W);
        put(QUEUE_FRAME_END);
      end
      3: begin
        put(QUEUE_FRAME_START); put_row(W); put_row(W); put(QUEUE_FRAME_END);
        put_clean_frame();
      end
      4: begin
        put(QUEUE_FRAME_START); put_row(W); put_row(4);
        put(QUEUE_FRAME_START); put_row(W); put_row(5);
        put(17'h10005); put_pixels(5); put_row(W);
        put(QUEUE_FRAME_END);
      end
      5: begin
        put(QUEUE_FRAME_START); put_row(W); put_row(7); put_row(W);
        put(QUEUE_FRAME_END);
      end
      6: begin
        put(QUEUE_FRAME_START);
        for (int r = 0; r < H; r++) put_row(W);
        put_row(5);
        put(QUEUE_FRAME_END);
      end
      default: begin
        put_pixels(2);
        put_clean_frame();
      end
    endcase
  endtask

  // Reference: walk the word list once, applying the framing rules directly.
  task automatic model_run();
    int row, col;
    bit in_frame, in_row, dropping;
    logic [16:0] w;
    pix_t e;
    row = 0; col = 0; in_frame = 0; in_row = 0; dropping = 0;
    model_err = '0; model_done = 0;
    foreach (stim_q[i]) begin
      w = stim_q[i];
      if (w == QUEUE_FRAME_START) begin
        if (in_frame) model_err[2] = 1'b1;
        in_frame = 1; in_row = 0; dropping = 0;
      end else if (!in_frame) begin
        model_err[3] = 1'b1;
      end else if (w == QUEUE_ROW_START) begin
        if (!in_row) begin
          in_row = 1; row = 0; col = 0;
        end else begin
          if (col != W) model_err[1] = 1'b1;
          if (row + 1 == H) begin
            model_err[2] = 1'b1; col = W; dropping = 1;
          end else begin
            row++; col = 0;
          end
        end
      end else if (w == QUEUE_FRAME_END) begin
        model_done++;
        if (!in_row || row != H - 1 || col != W) model_err[2] = 1'b1;
        in_frame = 0; in_row = 0; dropping = 0;
      end else if (w[16]) begin
        model_err[3] = 1'b1;
      end else if (!in_row) begin
        model_err[3] = 1'b1;
      end else if (col < W) begin
        e.d = w[15:0]; e.x = col; e.y = row;
        exp_q.push_back(e);
        col++;
      end else if (!dropping) begin
        model_err[0] = 1'b1;
      end
    end
  endtask

  task automatic load_fifo();
    foreach (stim_q[i]) begin
      fifo_mem[wr_ptr % 4096] = stim_q[i];
      wr_ptr++;
    end
    stim_q.delete();
  endtask

  task automatic run_until_idle(input int mode);
    bit idle;
    idle = 0;
    for (int k = 0; k < 3000 && !idle; k++) begin
      @(posedge clk); #1;
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (rd_ptr == wr_ptr && !pix_valid && exp_q.size() == 0) idle = 1;
    end
    if (!idle) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pixels pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) begin
      @(posedge clk); #1;
      pix_ready = 1'b1;
    end
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk("err_clear", 64'(err_flags), 64'd0);
  endtask

  vec_t tbl[9];
  int   rd_start;
  bit   seen;

  initial begin
    tbl[0] = '{0, 0, 4'b0000, 30, 1};
    tbl[1] = '{0, 1, 4'b0000, 30, 1};
    tbl[2] = '{0, 2, 4'b0000, 30, 1};
    tbl[3] = '{2, 0, 4'b0001, 30, 1};
    tbl[4] = '{3, 2, 4'b0100, 50, 2};
    tbl[5] = '{4, 1, 4'b1100, 44, 1};
    tbl[6] = '{5, 0, 4'b0010, 27, 1};
    tbl[7] = '{6, 2, 4'b0100, 30, 1};
    tbl[8] = '{7, 0, 4'b1000, 30, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_rd_en", 64'(queue_rd_en), 64'd0);
    chk("rst_err_flags", 64'(err_flags), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_flags", 64'({pix_sof, pix_eol, pix_eof}), 64'd0);
    reset_n = 1'b1;
    pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      build(tbl[i].kind);
      model_run();
      pix_cnt = 0; done_cnt = 0; first_acc = -1; last_acc = -1;
      load_fifo();
      run_until_idle(tbl[i].ready_mode);
      chk("err_flags", 64'(err_flags), 64'(tbl[i].exp_err));
      chk("err_vs_model", 64'(err_flags), 64'(model_err));
      chk("pix_count", 64'(pix_cnt), 64'(tbl[i].exp_pix));
      chk("frame_done_count", 64'(done_cnt), 64'(tbl[i].exp_done));
      if (tbl[i].kind == 0 && tbl[i].ready_mode == 0)
        chk("burst_span", 64'(last_acc - first_acc), 64'd31);
      $display("scenario %0d kind %0d ready_mode %0d: %0d pixels, err %b",
               i, tbl[i].kind, tbl[i].ready_mode, pix_cnt, err_flags);
      clear_errors();
    end

    // Reset with two pixels parked in the skid buffer.
    pix_ready = 1'b0;
    rd_start = rd_ptr;
    put(QUEUE_FRAME_START);
    put_row(5);
    load_fifo();
    repeat (12) @(posedge clk);
    #1;
    chk("pre_reset_valid", 64'(pix_valid), 64'd1);
    chk("pre_reset_reads", 64'(rd_ptr - rd_start), 64'd4);
    reset_n = 1'b0;
    #1;
    chk("reset_pix_valid", 64'(pix_valid), 64'd0);
    chk("reset_rd_en", 64'(queue_rd_en), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    pix_cnt = 0;
    run_until_idle(0);
    chk("post_reset_err", 64'(err_flags), 64'h8);
    chk("post_reset_pix", 64'(pix_cnt), 64'd0);
    $display("reset sequence: %0d pixels, err %b", pix_cnt, err_flags);
    clear_errors();

    // Error raised in the same cycle err_clear is asserted must survive.
    rd_start = rd_ptr;
    put(17'h10005);
    load_fifo();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (rd_ptr != rd_start) seen = 1;
    end
    chk("orphan_word_read", 64'(seen), 64'd1);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk("clear_vs_new_err", 64'(err_flags), 64'h8);
    chk("unknown_no_output", 64'(pix_valid), 64'd0);
    $display("clear collision: err %b", err_flags);
    clear_errors();

    // Clean frame after all the above.
    build(0);
    model_run();
    pix_cnt = 0; done_cnt = 0;
    load_fifo();
    run_until_idle(2);
    chk("final_err", 64'(err_flags), 64'd0);
    chk("final_pix_count", 64'(pix_cnt), 64'(W * H));
    chk("final_done_count", 64'(done_cnt), 64'd1);
    $display("final frame: %0d pixels, err %b", pix_cnt, err_flags);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_queue_unpacker.md
Name: frame_queue_unpacker

Overview:
- Sits directly downstream of the pixel queue (17-bit FIFO) fed by the camera path or the debug colour-bar generator.
- Pops queue words and decodes the in-band markers:
  - 0x10000 frame start
  - 0x10001 row start
  - 0x1FFFF frame end
  - bit16=0: RGB565 pixel
- Emits a valid/ready pixel stream tagged with x/y coordinates and SOF/EOL/EOF flags for the frame-buffer writer.
- Checks framing against FRAME_WIDTH/FRAME_HEIGHT and reports sticky errors.

Parameters:
FRAME_WIDTH, 480, pixels per row
FRAME_HEIGHT, 272, rows per frame
COORD_W, 11, width of x/y coordinate outputs

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
queue_empty  in  1  upstream FIFO empty
queue_rd_en  out  1  FIFO read strobe
queue_data  in  17  FIFO read data, valid exactly 1 cycle after queue_rd_en
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream accepts when high with pix_valid
pix_data  out  16  RGB565 pixel
pix_x  out  COORD_W  column 0..FRAME_WIDTH-1
pix_y  out  COORD_W  row 0..FRAME_HEIGHT-1
pix_sof  out  1  pixel is x=0,y=0
pix_eol  out  1  pixel is x=FRAME_WIDTH-1
pix_eof  out  1  pixel is x=W-1,y=H-1
frame_done  out  1  one-cycle pulse when frame-end marker decoded
err_flags  out  4  sticky errors, [0] row overflow, [1] short row, [2] frame geometry, [3] unknown marker/orphan pixel
err_clear  in  1  synchronous clear of err_flags

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, skid buffer empty, no read in flight. Reset mid-frame discards buffered pixels; no partial output.
- Read pipeline:
  - Internal 2-entry pixel skid buffer.
  - queue_rd_en = !queue_empty && (entries + inflight) < 2.
  - inflight is set for the cycle after rd_en.
  - Sustained rate is 1 pixel/cycle when pix_ready is held high.
- Read latency: queue_data is decoded in the cycle after rd_en (decode stage). A decoded pixel appears on pix_* no earlier than the following cycle.
- Output ordering and handshake:
  - Pixels leave in FIFO order.
  - pix_* stay stable while pix_valid && !pix_ready.
  - Flags are computed from the attached x/y.
- States:
  - IDLE:
    - frame start → FRAME (row=0 pending, first_row=1).
    - Pixel → dropped, err[3].
    - Row start or frame end → ignored, err[3].
  - FRAME (waiting first row start):
    - Row start → ROW, col=0, row=0.
    - Pixel → dropped, err[3].
  - ROW:
    - Pixel with col<FRAME_WIDTH → push {data,col,row}, col++.
    - Pixel with col==FRAME_WIDTH → dropped, err[0].
    - Row start → if col!=FRAME_WIDTH set err[1]. If row+1==FRAME_HEIGHT set err[2] and drop subsequent pixels until frame end (stay ROW with col=FRAME_WIDTH, no err[0] repeat). Else row++, col=0.
    - Frame end → frame_done pulse. If row!=H-1 or col!=W set err[2]. Go to IDLE.
  - Frame start in any non-IDLE state: resynchronise to FRAME, set err[2], no frame_done.
- Unknown marker (bit16=1, low word not 0000/0001/FFFF): ignored, err[3], state unchanged.
- frame_done timing: may precede the last pixel's departure from the skid buffer by up to 2 cycles; consumers use pix_eof for data completion.
- Error register:
  - err_flags OR-accumulate.
  - err_clear in the same cycle as a new error: the new error wins (bit stays set).
- Coordinate counters are COORD_W bits. Elaboration check: FRAME_WIDTH and FRAME_HEIGHT < 2**COORD_W.

Decomposition:
- Add to the shared queue package:
  - marker constants QUEUE_FRAME_START=17'h10000, QUEUE_ROW_START=17'h10001, QUEUE_FRAME_END=17'h1FFFF
  - unpacker state enum
  - err_flags bit-index constants
- One sub-module: pixel_skid_buffer (2-entry valid/ready register pair, parameterised data width), reusable by other stream stages.

Test Plan:
- Full frame with W=10,H=3 (markers, 30 pixels, frame end), pix_ready=1 → 30 pixels x/y raster order, sof on (0,0), eol on x=9, eof on (9,2), frame_done once, err_flags=0, sustained 1 pixel/cycle after 2-cycle fill.
- Same frame, pix_ready toggled 1-0-0-1 pattern, FIFO always non-empty → no loss or duplication, pix_* stable during stalls, queue_rd_en never leaves >2 entries+inflight.
- Row with 11 pixels (W=10) → 10 pixels out, 11th dropped, err_flags=4'b0001, next row starts at x=0.
- Frame end after 2 rows (H=3) → frame_done pulse, err_flags[2]=1, state IDLE; next clean frame outputs correctly.
- Frame start injected mid-row 1 → resync, err[2] set, following row starts at y=0; word 17'h10005 → err[3], no output.
- reset_n asserted mid-row with 2 pixels buffered → pix_valid=0 immediately, queue_rd_en=0, after release pixels before a frame start are dropped with err[3].
